// File: rtl/alu_param_pipe.sv
// alu_param_pipe: parametrised ALU core behind a single ready/start/done
// handshake. Single-cycle ops and the multiply/special pipeline share one
// IDLE/RUN/ERR controller.
//   clk, reset_n      : clock, asynchronous active-low reset
//   a, b, op, start   : command; captured on a rising edge with ready=1
//   ready             : controller is idle and will accept a command
//   result            : 2*WIDTH result of the last completed command
//   done, error       : one-cycle completion pulse; error flags a reserved op
module alu_param_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned SHAMT   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         op,
    input  logic               start,
    output logic               ready,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               error
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);
    localparam int unsigned NSTG  = MUL_LAT - 1;

    localparam logic [3:0] OP_NOP0 = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_SP0  = 4'h7;
    localparam logic [3:0] OP_SP1  = 4'h8;
    localparam logic [3:0] OP_SP2  = 4'h9;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]      pipe_q [NSTG];
    logic [W2-1:0]      pipe_d [NSTG];
    logic [W2-1:0]      sp0_q, sp0_d;
    logic [W2-1:0]      result_q, result_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               is_nop_c;
    logic               is_rsv_c;
    logic [CNT_W-1:0]   load_c;
    logic               accept_c;
    logic               rsv_accept_c;
    logic               finish_c;
    logic [W2-1:0]      alu_c;

    assign ready  = (state_q == S_IDLE);
    assign result = result_q;
    assign done   = done_q;
    assign error  = error_q;

    // Command decode on the live inputs; only meaningful while idle.
    always_comb begin
        is_nop_c = (op == OP_NOP0) || (op == OP_NOPF);
        is_rsv_c = (op >= 4'hA) && (op <= 4'hE);
        case (op)
            OP_MUL, OP_SP1, OP_SP2: load_c = CNT_W'(MUL_LAT - 1);
            OP_SP0:                 load_c = CNT_W'(MUL_LAT);
            default:                load_c = '0;
        endcase
        accept_c     = (state_q == S_IDLE) && start && !is_nop_c && !is_rsv_c;
        rsv_accept_c = (state_q == S_IDLE) && start && is_rsv_c;
        finish_c     = (state_q == S_RUN) && (cnt_q == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; nops leave the controller idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_RUN;
                end else if (rsv_accept_c) begin
                    state_d = S_ERR;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Final result select from captured operands or the pipeline tail.
    always_comb begin
        case (op_q)
            OP_ADD:                 alu_c = W2'(a_q) + W2'(b_q);
            OP_AND:                 alu_c = W2'(a_q & b_q);
            OP_XOR:                 alu_c = W2'(a_q ^ b_q);
            OP_SHL:                 alu_c = W2'(a_q) << SHAMT;
            OP_SHR:                 alu_c = W2'(a_q >> SHAMT);
            OP_MUL, OP_SP1, OP_SP2: alu_c = pipe_q[NSTG-1];
            OP_SP0:                 alu_c = sp0_q;
            default:                alu_c = '0;
        endcase
    end

    // Operand capture, latency counter, pipeline and registered outputs.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        if (accept_c) begin
            a_d   = a;
            b_d   = b;
            op_d  = op;
            cnt_d = load_c;
        end else if (rsv_accept_c) begin
            op_d = op;
        end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (finish_c) begin
            result_d = alu_c;
            done_d   = 1'b1;
        end else if (state_q == S_ERR) begin
            result_d = '0;
            done_d   = 1'b1;
            error_d  = 1'b1;
        end

        // First stage forms the product-like term; sp0 forms 2*B here and
        // adds A in the extra stage after the tail.
        case (op_q)
            OP_MUL:  pipe_d[0] = W2'(a_q) * W2'(b_q);
            OP_SP1:  pipe_d[0] = W2'(a_q) << 1;
            OP_SP2:  pipe_d[0] = W2'(a_q) + (W2'(a_q) << 1);
            OP_SP0:  pipe_d[0] = W2'(b_q) << 1;
            default: pipe_d[0] = '0;
        endcase
        for (int i = 1; i < int'(NSTG); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        sp0_d = pipe_q[NSTG-1] + W2'(a_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            sp0_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            for (int i = 0; i < int'(NSTG); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sp0_q    <= sp0_d;
            result_q <= result_d;
            done_q   <= done_d;
            error_q  <= error_d;
            for (int i = 0; i < int'(NSTG); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

endmodule
